// File: rtl/mem_arbiter_if.sv
// Bundle of CPU/DMA requester ports, single-port RAM ports and status for mem_arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output ram_addr, ram_wdata, ram_read, ram_write,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  ram_addr, ram_wdata, ram_read, ram_write,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU and a DMA requester access to one single-port RAM.
// Write acks 2 cycles after the request is sampled, read acks 2+RD_LAT; requests wait in IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clock,
  input  logic           clear,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              grant_dma;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cnt_d       = cnt_q;
    grant_dma   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          // On a tie the requester that did not own the last grant wins.
          grant_dma = bus.dma_req && (!bus.cpu_req || !owner_q);
          owner_d   = grant_dma;
          we_d      = grant_dma ? bus.dma_we    : bus.cpu_we;
          addr_d    = grant_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d   = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (owner_q) dma_rdata_d = bus.ram_rdata;
          else         cpu_rdata_d = bus.ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_write = (state_q == ACCESS) &&  we_q;
  assign bus.ram_read  = (state_q == ACCESS) && !we_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
  assign bus.cpu_ack   = (state_q == DONE) && !owner_q;
  assign bus.dma_ack   = (state_q == DONE) &&  owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles after the read strobe (legal range 1-7).
REQ-004 The block SHALL have one clock and an asynchronous active-high reset; ports are named clock and clear.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 clear  in  1  asynchronous active-high reset.
REQ-007 cpu_req / cpu_we  in  1 / 1  CPU access request; write when cpu_we=1, read otherwise.
REQ-008 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data (MAR/MDR side).
REQ-009 cpu_ack / cpu_rdata  out  1 / DATA_W  one-cycle completion pulse; captured read data.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the DMA/loader requester.
REQ-011 ram_addr / ram_wdata  out  ADDR_W / DATA_W  address and write data to the single-port RAM.
REQ-012 ram_read / ram_write  out  1 / 1  RAM strobes; never both high.
REQ-013 ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the ram_read cycle.
REQ-014 busy / owner  out  1 / 1  transaction in progress; owner of the current or most recent grant (0=CPU, 1=DMA).

Function
REQ-015 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-016 IDLE: with no request, remain in IDLE; with any request, grant one requester, latch its we/addr/wdata, set owner, go to ACCESS.
REQ-017 Arbitration: single request -> grant it; both requesting -> grant the requester that is not owner (round-robin).
REQ-018 ACCESS (1 cycle): drive the latched address; ram_write=1 with ram_wdata=latched data for writes, ram_read=1 for reads; next state DONE for writes, WAIT for reads.
REQ-019 WAIT: last for exactly RD_LAT cycles, counted by a down-counter loaded with RD_LAT-1 on entry; capture ram_rdata on the final WAIT edge into the owner's rdata register; next state DONE.
REQ-020 DONE (1 cycle): the owner's ack=1, the other ack=0; next state IDLE.
REQ-021 ram_addr/ram_wdata SHALL hold the latched values outside ACCESS; strobes are 0 in every state except ACCESS.
REQ-022 cpu_rdata/dma_rdata change only on completion of a read by that requester; otherwise hold.
REQ-023 busy=1 in ACCESS, WAIT, DONE; 0 in IDLE.
REQ-024 Latency from a request sampled in IDLE at edge n: write -> ram_write in cycle n+1, ack in n+2; read -> ram_read in n+1, ack in n+2+RD_LAT with rdata valid.
REQ-025 Requesters hold req and command stable until ack. A req still high in the cycle after ack is a new request. A req dropped mid-transaction does not abort; the transaction completes and acks.
REQ-026 Requests arriving while busy are not sampled until IDLE; no queueing beyond the request level.
REQ-027 Minimum spacing: DONE->IDLE->ACCESS, i.e. back-to-back writes complete every 3 cycles.

Reset
REQ-028 clear=1 SHALL immediately force: state=IDLE, ram_read=ram_write=0, cpu_ack=dma_ack=0, busy=0, owner=1 (so the CPU wins the first tie), ram_addr=0, ram_wdata=0, cpu_rdata=dma_rdata=0, WAIT counter=0.
REQ-029 clear during ACCESS/WAIT/DONE SHALL abandon the transaction with no ack; arbitration restarts in the cycle after clear deasserts.

Verification
REQ-030 After reset, cpu_req=dma_req=1 (both reads) -> CPU granted first (owner=0), cpu_ack at n+3 (RD_LAT=1); DMA granted next; owner=1, dma_ack follows.
REQ-031 CPU write addr=0x005, data=0xDEADBEEF -> ram_write=1 with addr 0x005 and data 0xDEADBEEF in n+1; cpu_ack in n+2; CPU read of 0x005 returns 0xDEADBEEF.
REQ-032 Both request continuously for 6 grants -> owner alternates 0,1,0,1,0,1; never two acks in the same cycle.
REQ-033 RD_LAT=3, DMA read -> ram_read for exactly 1 cycle; 3 WAIT cycles; dma_ack at n+5; cpu_rdata unchanged.
REQ-034 clear asserted in WAIT -> strobes and busy 0 immediately; no ack; rdata registers 0; the next request is served normally.
REQ-035 cpu_req dropped in the ACCESS cycle of a write -> write still performed; cpu_ack pulses in n+2.
